// File: rtl/uart_autobaud_ctrl.sv
// Auto-baud controller: measures the bit period from a 0x55 sync character on
// the raw rx line, programs the UART receiver's clks_per_bit, gates its
// enable while locked, and drops lock on relock request or line break.
module uart_autobaud_ctrl #(
    parameter int CLK_HZ       = 10_000_000,
    parameter int CNT_WIDTH    = $clog2(CLK_HZ/115200)+1,
    parameter int DEFAULT_CLKS = CLK_HZ/115200,
    parameter int MIN_CLKS     = 8,
    parameter int IDLE_CLKS    = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 relock,
    output logic                 rx_enable,
    output logic [CNT_WIDTH-1:0] clks_per_bit,
    output logic                 locked,
    output logic                 lock_err,
    output logic                 break_det
);
    localparam int MW = CNT_WIDTH + 3;   // measure counter / slen / meas
    localparam int RW = CNT_WIDTH + 4;   // high/low run counter
    localparam int CW = CNT_WIDTH + 1;   // rounded period, one spare bit

    typedef enum logic [2:0] {
        IDLE_WAIT, ARMED, MEASURE, CHECK, STOP_WAIT, LOCKED
    } state_t;

    state_t         state, state_nxt;
    logic           sync1, s, s_d;
    logic           fall, rise;
    logic [MW-1:0]  mcnt, mcnt_nxt, slen, slen_nxt, meas, meas_nxt;
    logic [2:0]     fe, fe_nxt;
    logic [RW-1:0]  run, run_nxt;
    logic           lock_err_nxt, break_nxt, load_cpb;
    logic [MW:0]    meas_rnd, slen_x, cpb_x, sdiff;
    logic [CW-1:0]  cpb;
    logic [RW-1:0]  brk_lim;
    logic           cpb_ok;

    assign fall = s_d & ~s;
    assign rise = ~s_d & s;

    // Eight bit periods measured; round to nearest single period. A result
    // that does not fit in clks_per_bit is rejected rather than truncated.
    assign meas_rnd = {1'b0, meas} + (MW+1)'(4);
    assign cpb      = meas_rnd[MW:3];
    assign slen_x   = {1'b0, slen};
    assign cpb_x    = (MW+1)'(cpb);
    assign sdiff    = (slen_x >= cpb_x) ? slen_x - cpb_x : cpb_x - slen_x;
    assign cpb_ok   = (cpb >= CW'(MIN_CLKS)) && !cpb[CW-1] &&
                      (sdiff <= (MW+1)'(cpb >> 2));

    // Break threshold: 11 bit periods, built from shifts and adds.
    assign brk_lim = (RW'(clks_per_bit) << 3) + (RW'(clks_per_bit) << 1)
                   + RW'(clks_per_bit);

    assign locked    = (state == LOCKED);
    assign rx_enable = (state == LOCKED);

    // Two-flop synchronizer plus one delay stage for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            s     <= 1'b1;
            s_d   <= 1'b1;
        end else begin
            sync1 <= rx;
            s     <= sync1;
            s_d   <= s;
        end
    end

    // State, counters, registered pulses and the programmed bit period.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE_WAIT;
            mcnt         <= '0;
            slen         <= '0;
            meas         <= '0;
            fe           <= '0;
            run          <= '0;
            lock_err     <= 1'b0;
            break_det    <= 1'b0;
            clks_per_bit <= CNT_WIDTH'(DEFAULT_CLKS);
        end else begin
            state     <= state_nxt;
            mcnt      <= mcnt_nxt;
            slen      <= slen_nxt;
            meas      <= meas_nxt;
            fe        <= fe_nxt;
            run       <= run_nxt;
            lock_err  <= lock_err_nxt;
            break_det <= break_nxt;
            if (load_cpb)
                clks_per_bit <= cpb[CNT_WIDTH-1:0];
        end
    end

    // Next-state and counter updates; relock overrides everything at the end.
    always_comb begin
        state_nxt    = state;
        mcnt_nxt     = mcnt;
        slen_nxt     = slen;
        meas_nxt     = meas;
        fe_nxt       = fe;
        run_nxt      = run;
        lock_err_nxt = 1'b0;
        break_nxt    = 1'b0;
        load_cpb     = 1'b0;
        case (state)
            IDLE_WAIT: begin
                if (!s)
                    run_nxt = '0;
                else if (run + RW'(1) >= RW'(IDLE_CLKS)) begin
                    run_nxt   = '0;
                    state_nxt = ARMED;
                end else
                    run_nxt = run + RW'(1);
            end
            ARMED: begin
                mcnt_nxt = '0;
                slen_nxt = '0;
                fe_nxt   = '0;
                if (fall)
                    state_nxt = MEASURE;
            end
            MEASURE: begin
                if (&mcnt) begin
                    lock_err_nxt = 1'b1;
                    run_nxt      = '0;
                    state_nxt    = IDLE_WAIT;
                end else begin
                    mcnt_nxt = mcnt + MW'(1);
                    // slen of zero marks "start bit not yet ended"
                    if (rise && slen == '0)
                        slen_nxt = mcnt + MW'(1);
                    if (fall) begin
                        if (fe == 3'd3) begin
                            meas_nxt  = mcnt + MW'(1);
                            state_nxt = CHECK;
                        end else
                            fe_nxt = fe + 3'd1;
                    end
                end
            end
            CHECK: begin
                run_nxt = '0;
                if (cpb_ok) begin
                    load_cpb  = 1'b1;
                    state_nxt = STOP_WAIT;
                end else begin
                    lock_err_nxt = 1'b1;
                    state_nxt    = IDLE_WAIT;
                end
            end
            STOP_WAIT: begin
                if (!s)
                    run_nxt = '0;
                else if (run + RW'(1) >= RW'(clks_per_bit)) begin
                    run_nxt   = '0;
                    state_nxt = LOCKED;
                end else
                    run_nxt = run + RW'(1);
            end
            LOCKED: begin
                if (s)
                    run_nxt = '0;
                else if (run + RW'(1) >= brk_lim) begin
                    run_nxt   = '0;
                    break_nxt = 1'b1;
                    state_nxt = IDLE_WAIT;
                end else
                    run_nxt = run + RW'(1);
            end
            default: begin
                run_nxt   = '0;
                state_nxt = IDLE_WAIT;
            end
        endcase
        if (relock) begin
            state_nxt    = IDLE_WAIT;
            run_nxt      = '0;
            lock_err_nxt = 1'b0;
            break_nxt    = 1'b0;
            load_cpb     = 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Bench for uart_autobaud_ctrl: builds line waveforms as per-cycle queues,
// predicts the outcome from edge positions in the waveform, and compares.
module tb_uart_autobaud_ctrl;
    localparam int CPB_W    = 8;
    localparam int DEF_CLKS = 10_000_000 / 115200;
    localparam int IDLE_N   = 64;
    localparam int MIN_N    = 8;
    localparam int MCNT_MAX = 2047;

    logic             clk = 1'b0;
    logic             rst, rx, relock;
    logic             rx_enable, locked, lock_err, break_det;
    logic [CPB_W-1:0] clks_per_bit;

    int checks = 0, errors = 0;
    int tot_err = 0, tot_brk = 0;
    bit err_d = 0, brk_d = 0;
    bit line[$];
    int cur_cpb = DEF_CLKS;
    int last_fall;

    uart_autobaud_ctrl dut (
        .clk(clk), .rst(rst), .rx(rx), .relock(relock),
        .rx_enable(rx_enable), .clks_per_bit(clks_per_bit),
        .locked(locked), .lock_err(lock_err), .break_det(break_det)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Pulse bookkeeping: one-cycle width, never both at once.
    always @(negedge clk) begin
        if (lock_err || break_det)
            check("pulse_excl", int'(lock_err & break_det), 0);
        if (lock_err) begin
            check("err_width", int'(err_d), 0);
            tot_err++;
        end
        if (break_det) begin
            check("brk_width", int'(brk_d), 0);
            tot_brk++;
        end
        err_d = lock_err;
        brk_d = break_det;
    end

    task automatic add(input bit v, input int n);
        repeat (n) line.push_back(v);
    endtask

    // UART frame, LSB first, with optional +/-jit cycles on each edge.
    task automatic add_frame(input logic [7:0] b, input int p, input int jit);
        int e[11];
        int base;
        bit lvl;
        base = line.size();
        for (int k = 0; k <= 10; k++)
            e[k] = k * p + ((k == 0 || jit == 0) ? 0 :
                            int'($urandom_range(0, 2 * jit)) - jit);
        last_fall = base + e[8];
        for (int k = 0; k < 10; k++) begin
            lvl = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            add(lvl, e[k+1] - e[k]);
        end
    endtask

    function automatic int find_run(input int from, input bit v, input int len);
        int cnt = 0;
        for (int i = from; i < line.size(); i++) begin
            cnt = (line[i] == v) ? cnt + 1 : 0;
            if (cnt >= len) return i;
        end
        return -1;
    endfunction

    // Reference: walk the line as seen by the controller (index 0 = first
    // idle cycle) and predict lock errors, breaks, final lock and period.
    function automatic void model(inout int cpb, output int errs,
                                  output int brks, output bit lk);
        int pos, a, f, g, r, nf, t, c8, sl, df, b, c, n;
        errs = 0; brks = 0; lk = 0; pos = 0; n = line.size();
        while (1) begin
            a = find_run(pos, 1'b1, IDLE_N);
            if (a < 0) return;
            f = -1;
            for (int i = a + 1; i < n; i++)
                if (!line[i]) begin f = i; break; end
            if (f < 0) return;
            g = -1; r = -1; nf = 0;
            for (int i = f + 1; i < n && i <= f + MCNT_MAX; i++) begin
                if (line[i] && !line[i-1] && r < 0) r = i;
                if (!line[i] && line[i-1]) begin
                    nf++;
                    if (nf == 4) begin g = i; break; end
                end
            end
            if (g < 0) begin
                if (f + MCNT_MAX + 2 < n) begin
                    errs++;
                    pos = f + MCNT_MAX + 2;
                    continue;
                end
                return;
            end
            t  = g - f;
            c8 = (t + 4) >> 3;
            sl = r - f;
            df = (sl > c8) ? sl - c8 : c8 - sl;
            if (c8 < MIN_N || c8 > 255 || df > (c8 >> 2)) begin
                errs++;
                pos = g + 2;
                continue;
            end
            cpb = c8;
            b = find_run(g + 2, 1'b1, cpb);
            if (b < 0) return;
            c = find_run(b + 1, 1'b0, 11 * cpb);
            if (c < 0) begin lk = 1; return; end
            brks++;
            pos = c + 1;
        end
    endfunction

    // Relock, drive the queued line, then compare against the model.
    task automatic run_scn(input string tag, input int relock_at);
        int  exp_cpb, exp_err, exp_brk, e0, b0;
        bit  exp_lk;
        bit  save[$];
        exp_cpb = cur_cpb;
        if (relock_at >= 0) begin
            save = line;
            line = line[relock_at:$];
            model(exp_cpb, exp_err, exp_brk, exp_lk);
            line = save;
        end else
            model(exp_cpb, exp_err, exp_brk, exp_lk);
        @(negedge clk);
        relock = 1'b1; rx = 1'b1;
        e0 = tot_err; b0 = tot_brk;
        for (int i = 0; i < line.size(); i++) begin
            @(negedge clk);
            rx = line[i];
            relock = (i == relock_at);
        end
        repeat (10) begin
            @(negedge clk);
            rx = 1'b1; relock = 1'b0;
        end
        check({tag, ".cpb"},    int'(clks_per_bit), exp_cpb);
        check({tag, ".locked"}, int'(locked),       int'(exp_lk));
        check({tag, ".rx_en"},  int'(rx_enable),    int'(exp_lk));
        check({tag, ".errs"},   tot_err - e0,       exp_err);
        check({tag, ".brks"},   tot_brk - b0,       exp_brk);
        cur_cpb = exp_cpb;
        line.delete();
    endtask

    initial begin
        int p, jit;
        rst = 1'b1; rx = 1'b1; relock = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.rx_en",  int'(rx_enable),    0);
        check("rst.locked", int'(locked),       0);
        check("rst.cpb",    int'(clks_per_bit), DEF_CLKS);
        check("rst.err",    int'(lock_err),     0);
        check("rst.brk",    int'(break_det),    0);
        rst = 1'b0;

        add(1, 100); add_frame(8'h55, 87, 0); add(1, 300);
        run_scn("p87", -1);
        check("p87.spec", int'(clks_per_bit), 87);

        add(1, 100); add_frame(8'h55, 86, 1); add(1, 300);
        run_scn("p86j", -1);
        check("p86j.spec", int'(clks_per_bit), 86);

        add(1, 100); add_frame(8'h00, 87, 0); add(1, 2200);
        run_scn("b00", -1);

        add(1, 100); add_frame(8'hF0, 87, 0); add(1, 2200);
        run_scn("bF0", -1);

        // long start bit, then regular edges: start-length check rejects
        add(1, 100); add(0, 120);
        repeat (4) begin add(1, 40); add(0, 40); end
        add(1, 300);
        run_scn("slen", -1);

        add(1, 100); add_frame(8'h55, 1041, 0); add(1, 2200);
        run_scn("ovf", -1);
        check("ovf.spec", int'(clks_per_bit), 86);

        // one cycle short of the break threshold, then exactly at it
        add(1, 100); add_frame(8'h55, 87, 0); add(1, 300);
        add(0, 956); add(1, 200); add(0, 957); add(1, 300);
        run_scn("brk", -1);
        check("brk.spec", int'(clks_per_bit), 87);

        add(1, 100); add_frame(8'h55, 50, 0); add(1, 300);
        run_scn("p50", -1);
        check("p50.spec", int'(clks_per_bit), 50);

        // relock lands on the cycle the 4th falling edge is detected
        add(1, 100); add_frame(8'h55, 60, 0); add(1, 300);
        run_scn("rlk", last_fall + 2);
        check("rlk.spec", int'(clks_per_bit), 50);

        // synchronous reset in the middle of a measurement
        add(1, 100); add_frame(8'h55, 60, 0);
        for (int i = 0; i < 100 + 3 * 60; i++) begin
            @(negedge clk);
            rx = line[i];
        end
        check("mrst.pre", int'(clks_per_bit), cur_cpb);
        @(negedge clk);
        rst = 1'b1; rx = 1'b1;
        @(negedge clk);
        check("mrst.rx_en",  int'(rx_enable),    0);
        check("mrst.locked", int'(locked),       0);
        check("mrst.cpb",    int'(clks_per_bit), DEF_CLKS);
        check("mrst.err",    int'(lock_err),     0);
        check("mrst.brk",    int'(break_det),    0);
        rst = 1'b0;
        line.delete();
        cur_cpb = DEF_CLKS;

        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                p = $urandom_range(3, 7); jit = 0;
            end else begin
                p = $urandom_range(12, 200); jit = $urandom_range(0, 1);
            end
            add(1, $urandom_range(100, 300));
            add_frame(8'h55, p, jit);
            add(1, 300);
            run_scn("rnd", -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
